// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types, sync polarity constants and frame size helpers for the video timing generator
package video_pkg;

    localparam int PIX_BITS_DEFAULT = 24;

    typedef logic [PIX_BITS_DEFAULT-1:0] pixel_t;

    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    // Total pixels per line: visible area plus front porch/sync (stop) plus back porch.
    function automatic int htotal(input int visible, input int sync_stop, input int back_porch);
        return visible + sync_stop + back_porch;
    endfunction

    // Total lines per frame, same composition as htotal.
    function automatic int vtotal(input int visible, input int sync_stop, input int back_porch);
        return visible + sync_stop + back_porch;
    endfunction

endpackage

// File: rtl/video_testpattern.sv
// rtl/video_testpattern.sv - coordinate/frame test pattern {hpix[7:0], vpix[7:0], frame[7:0]}
module video_testpattern
    import video_pkg::*;
#(
    parameter int HW         = 10,
    parameter int VW         = 10,
    parameter int FRAME_BITS = 8,
    parameter int PIX_BITS   = PIX_BITS_DEFAULT
) (
    input  logic [HW-1:0]         hpix,
    input  logic [VW-1:0]         vpix,
    input  logic [FRAME_BITS-1:0] frame,
    output logic [PIX_BITS-1:0]   pattern
);

    logic [23:0] rgb;

    // Low byte of each coordinate and of the frame count, packed as R/G/B.
    always_comb begin
        rgb     = {8'(hpix), 8'(vpix), 8'(frame)};
        pattern = PIX_BITS'(rgb);
    end

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator with memory-latency-matched outputs; optional VIDEO_TESTPATTERN_EN
module video_timing_gen
    import video_pkg::*;
#(
    parameter int HPIX_VISIBLE = 640,
    parameter int VPIX_VISIBLE = 480,
    parameter int HSYNC_START  = 16,
    parameter int HSYNC_STOP   = 112,
    parameter int HSYNC_DELAY  = 48,
    parameter int VSYNC_START  = 10,
    parameter int VSYNC_STOP   = 12,
    parameter int VSYNC_DELAY  = 33,
    parameter bit HSYNC_POL    = SYNC_ACTIVE_LOW,
    parameter bit VSYNC_POL    = SYNC_ACTIVE_LOW,
    parameter int MEM_LATENCY  = 1,
    parameter int PIX_BITS     = PIX_BITS_DEFAULT,
    parameter int FRAME_BITS   = 8,
    localparam int HTOTAL      = htotal(HPIX_VISIBLE, HSYNC_STOP, HSYNC_DELAY),
    localparam int VTOTAL      = vtotal(VPIX_VISIBLE, VSYNC_STOP, VSYNC_DELAY),
    localparam int HW          = $clog2(HTOTAL),
    localparam int VW          = $clog2(VTOTAL),
    localparam int AW          = $clog2(HPIX_VISIBLE * VPIX_VISIBLE)
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    input  logic [PIX_BITS-1:0]   in_mem,
`ifdef VIDEO_TESTPATTERN_EN
    input  logic                  in_testpattern,
`endif
    output logic [AW-1:0]         out_addr,
    output logic [HW-1:0]         out_hpix_raw,
    output logic [VW-1:0]         out_vpix_raw,
    output logic                  out_hsync,
    output logic                  out_vsync,
    output logic                  out_pixel_enable,
    output logic [HW-1:0]         out_hpix,
    output logic [VW-1:0]         out_vpix,
    output logic [PIX_BITS-1:0]   out_pixel,
    output logic                  out_line_start,
    output logic                  out_frame_start,
    output logic [FRAME_BITS-1:0] out_frame
);

    // One delay stage per memory latency cycle plus the output register stage.
    localparam int D = MEM_LATENCY + 1;

    localparam logic [31:0] H_VIS  = 32'(HPIX_VISIBLE);
    localparam logic [31:0] V_VIS  = 32'(VPIX_VISIBLE);
    localparam logic [31:0] HS_ON  = 32'(HPIX_VISIBLE + HSYNC_START);
    localparam logic [31:0] HS_OFF = 32'(HPIX_VISIBLE + HSYNC_STOP);
    localparam logic [31:0] VS_ON  = 32'(VPIX_VISIBLE + VSYNC_START);
    localparam logic [31:0] VS_OFF = 32'(VPIX_VISIBLE + VSYNC_STOP);

    // Syncs are carried as "active" flags so a cleared stage is always inactive;
    // valid marks stages filled since reset so cleared zeros never fake a pulse.
    typedef struct packed {
        logic          valid;
        logic          hs;
        logic          vs;
        logic          en;
        logic [VW-1:0] v;
        logic [HW-1:0] h;
    } stage_t;

    logic [HW-1:0]       h_cnt;
    logic [VW-1:0]       v_cnt;
    logic [31:0]         h32;
    logic [31:0]         v32;
    stage_t              raw_s;
    stage_t              pipe [1:D];
    stage_t              dly;
    logic                pre_en;
    logic                frame_seen;
    logic [PIX_BITS-1:0] pix_src;

    // Free-running raster counters: h every cycle, v on each h wrap.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HW'(HTOTAL - 1)) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VW'(VTOTAL - 1)) ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Undelayed timing decode and framebuffer address.
    always_comb begin
        h32         = 32'(h_cnt);
        v32         = 32'(v_cnt);
        raw_s       = '0;
        raw_s.valid = 1'b1;
        raw_s.h     = h_cnt;
        raw_s.v     = v_cnt;
        raw_s.en    = (h32 < H_VIS) && (v32 < V_VIS);
        raw_s.hs    = (h32 >= HS_ON) && (h32 < HS_OFF);
        raw_s.vs    = (v32 >= VS_ON) && (v32 < VS_OFF);
        out_addr    = raw_s.en ? AW'(v32 * H_VIS + h32) : '0;
    end

    // Timing delay line matching the pixel memory read latency.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            for (int k = 1; k <= D; k++) pipe[k] <= '0;
        end else begin
            pipe[1] <= raw_s;
            for (int k = 2; k <= D; k++) pipe[k] <= pipe[k-1];
        end
    end

    // Enable as seen when the memory data for that pixel arrives.
    generate
        if (MEM_LATENCY == 0) begin : g_pre_lat0
            assign pre_en = raw_s.en;
        end else begin : g_pre_latn
            assign pre_en = pipe[MEM_LATENCY].en;
        end
    endgenerate

`ifdef VIDEO_TESTPATTERN_EN
    logic [HW-1:0]       pre_h;
    logic [VW-1:0]       pre_v;
    logic [PIX_BITS-1:0] pattern;

    generate
        if (MEM_LATENCY == 0) begin : g_tp_lat0
            assign pre_h = raw_s.h;
            assign pre_v = raw_s.v;
        end else begin : g_tp_latn
            assign pre_h = pipe[MEM_LATENCY].h;
            assign pre_v = pipe[MEM_LATENCY].v;
        end
    endgenerate

    video_testpattern #(
        .HW         (HW),
        .VW         (VW),
        .FRAME_BITS (FRAME_BITS),
        .PIX_BITS   (PIX_BITS)
    ) u_testpattern (
        .hpix    (pre_h),
        .vpix    (pre_v),
        .frame   (out_frame),
        .pattern (pattern)
    );

    assign pix_src = in_testpattern ? pattern : in_mem;
`else
    assign pix_src = in_mem;
`endif

    // Pixel output register, blanked outside the visible area.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_pixel <= '0;
        end else begin
            out_pixel <= pre_en ? pix_src : '0;
        end
    end

    // Frame counter holds 0 through the first frame after reset, then counts starts.
    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            out_frame  <= '0;
            frame_seen <= 1'b0;
        end else if (out_frame_start) begin
            if (frame_seen) out_frame <= out_frame + FRAME_BITS'(1);
            frame_seen <= 1'b1;
        end
    end

    assign dly          = pipe[D];
    assign out_hpix_raw = h_cnt;
    assign out_vpix_raw = v_cnt;

    // Delayed outputs decoded from the last delay stage.
    always_comb begin
        out_hsync        = dly.hs ? HSYNC_POL : ~HSYNC_POL;
        out_vsync        = dly.vs ? VSYNC_POL : ~VSYNC_POL;
        out_pixel_enable = dly.en;
        out_hpix         = dly.en ? dly.h : '0;
        out_vpix         = dly.en ? dly.v : '0;
        out_line_start   = dly.valid && (dly.h == '0) && (32'(dly.v) < V_VIS);
        out_frame_start  = dly.valid && (dly.h == '0) && (dly.v == '0);
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameters: HPIX_VISIBLE, default 640, visible pixels per line; VPIX_VISIBLE, default 480, visible lines per frame.
REQ-002 SHALL have parameters: HSYNC_START 16, HSYNC_STOP 112, HSYNC_DELAY 48, horizontal front porch, sync end and back porch in pixels after visible area; VSYNC_START 10, VSYNC_STOP 12, VSYNC_DELAY 33, the same in lines.
REQ-003 SHALL have parameters: HSYNC_POL 0 and VSYNC_POL 0, active sync level; MEM_LATENCY 1, pixel-memory read latency in cycles (0..4); PIX_BITS 24; FRAME_BITS 8.
REQ-004 in_clk  in  1  single clock; all logic on rising edge.
REQ-005 in_rst  in  1  synchronous, active-high reset.
REQ-006 in_mem  in  PIX_BITS  pixel data, valid MEM_LATENCY cycles after out_addr.
REQ-007 out_addr  out  clog2(HVIS*VVIS)  framebuffer address, combinational from raw counters.
REQ-008 out_hpix_raw, out_vpix_raw  out  clog2(HTOTAL), clog2(VTOTAL)  undelayed counters.
REQ-009 out_hsync, out_vsync, out_pixel_enable  out  1 each  delayed sync and visible flag.
REQ-010 out_hpix, out_vpix  out  same widths as raw  delayed visible coordinates.
REQ-011 out_pixel  out  PIX_BITS  delayed pixel; out_line_start, out_frame_start  out  1  one-cycle pulses; out_frame  out  FRAME_BITS  frame counter.

Function
REQ-012 HTOTAL SHALL equal HPIX_VISIBLE+HSYNC_STOP+HSYNC_DELAY; VTOTAL likewise.
REQ-013 h counter SHALL increment every cycle, wrap HTOTAL-1 -> 0; v SHALL increment on h wrap, wrap VTOTAL-1 -> 0.
REQ-014 raw hsync SHALL be active for HVIS+HSYNC_START <= h < HVIS+HSYNC_STOP; raw vsync for VVIS+VSYNC_START <= v < VVIS+VSYNC_STOP; active level from *_POL.
REQ-015 raw enable SHALL be h<HVIS and v<VVIS; out_addr SHALL be v*HVIS+h when enabled, else 0.
REQ-016 out_hsync, out_vsync, out_pixel_enable, out_hpix, out_vpix, out_pixel SHALL lag raw counters by exactly MEM_LATENCY+1 cycles through one register delay line.
REQ-017 out_pixel SHALL be registered in_mem when delayed enable is high, else 0; out_hpix/out_vpix SHALL be 0 outside visible area.
REQ-018 out_line_start SHALL pulse when delayed h==0 and delayed v<VVIS; out_frame_start when delayed h==0 and v==0.
REQ-019 out_frame SHALL increment on each out_frame_start after the first post-reset frame, wrapping modulo 2^FRAME_BITS.

Reset
REQ-020 in_rst high SHALL force h=v=0, clear the delay line, out_frame=0, pulses 0, out_pixel=0, syncs inactive level; applies mid-frame identically.
REQ-021 After in_rst falls, raw counters SHALL start at 0 on the next edge; first out_frame_start SHALL appear MEM_LATENCY+1 cycles later.

Configuration
REQ-022 Macro VIDEO_TESTPATTERN_EN SHALL add input in_testpattern (1 bit).
REQ-023 With macro, in_testpattern high SHALL replace in_mem by pattern {hpix[7:0], vpix[7:0], out_frame[7:0]} on delayed coordinates, at same latency; switching SHALL take effect on the next pixel.
REQ-024 Without macro, port and pattern logic SHALL be absent; out_pixel always from in_mem.

Structure
REQ-025 Package video_pkg SHALL hold pixel type (PIX_BITS), sync-polarity constants and HTOTAL/VTOTAL helper functions.
REQ-026 Pattern logic SHALL be sub-module video_testpattern, instantiated only under VIDEO_TESTPATTERN_EN.

Verification (HVIS=VVIS=4, HSYNC 0/1/2, VSYNC 0/2/2, POL 0, MEM_LATENCY 1)
REQ-027 Free-run: h wraps 6->0, v wraps 7->0, frame = 56 cycles; raw hsync low only at h=4.
REQ-028 Latency: drive in_mem = f(out_addr) via 1-cycle memory model -> out_pixel at (x,y) equals f(y*4+x), with syncs aligned 2 cycles after raw.
REQ-029 Vsync: raw vsync low for v=4,5 (14 cycles); out_frame increments 0->1->2 on successive frame starts.
REQ-030 Reset at h=2,v=3 -> next cycle all outputs at reset values; counters restart at 0.
REQ-031 VIDEO_TESTPATTERN_EN, in_testpattern=1, frame 0 -> pixel at (3,2) = 24'h030200; toggle mid-line switches next pixel.
